// File: rtl/sram_mem_stage_if.sv
// External 16-bit SRAM bus seen by the MEM stage.
// master: the MEM stage drives address, strobes and write data.
// slave:  the SRAM (or its model) returns read data.
interface sram_mem_stage_if #(
    parameter int SRAM_ADDR_W = 18
);
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic                   sram_we_n;
    logic [15:0]            sram_dq_out;
    logic                   sram_dq_oe;
    logic [15:0]            sram_dq_in;

    modport master (
        output sram_addr,
        output sram_we_n,
        output sram_dq_out,
        output sram_dq_oe,
        input  sram_dq_in
    );

    modport slave (
        input  sram_addr,
        input  sram_we_n,
        input  sram_dq_out,
        input  sram_dq_oe,
        output sram_dq_in
    );
endinterface

// File: rtl/sram_mem_stage.sv
// MEM pipeline stage: splits each 32-bit load/store into two 16-bit SRAM
// transfers (low half first), freezes upstream via 'ready' while busy, and
// passes the WB controls through to MEM_stage_reg.
//
// Handshake: a memory request (mem_r_en_in | mem_w_en_in) acts as 'valid'
// from the EXE stage register. 'ready' is 0 from the cycle the request is
// seen until the access finishes; it returns to 1 in DONE, and the upstream
// stages advance on that DONE edge. The EXE register must hold its outputs
// stable while ready = 0. A request still present in DONE is not a new one.
module sram_mem_stage #(
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] st_val_in,
    input  logic [3:0]  wb_reg_dest_in,
    output logic        ready,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic [31:0] alu_result_out,
    output logic [3:0]  wb_reg_dest_out,
    output logic [31:0] data_memory_result,
    output logic [1:0]  dbg_state,
    sram_mem_stage_if.master sram
);

    localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam int              WORD_W   = SRAM_ADDR_W - 1;
    localparam logic [31:0]     BASE     = 32'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      lo_q, lo_d;
    logic [15:0]      hi_q, hi_d;
    logic             store_q, store_d;

    logic              req;
    logic              in_access;
    logic              half_sel;
    logic [WORD_W-1:0] word_idx;

    assign req = mem_r_en_in | mem_w_en_in;

    // Word index relative to the SRAM base; upper bits drop so addresses wrap.
    assign word_idx = WORD_W'((alu_result_in - BASE) >> 2);

    // Next-state logic: sequence the two half-word transfers, capture load data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        store_d = store_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_LO;
                    cnt_d   = '0;
                    // Store wins when both enables are set.
                    store_d = mem_w_en_in;
                end
            end
            S_LO: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                    if (!store_q) begin
                        lo_d = sram.sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HI: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (!store_q) begin
                        hi_d = sram.sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // Always return to IDLE; the held request is the one just served.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and data registers; async reset aborts any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            store_q <= store_d;
        end
    end

    assign in_access = (state_q == S_LO) || (state_q == S_HI);
    assign half_sel  = (state_q == S_HI);

    // SRAM bus drive: address and strobes only while a transfer is on the bus.
    always_comb begin
        sram.sram_addr   = '0;
        sram.sram_we_n   = 1'b1;
        sram.sram_dq_oe  = 1'b0;
        sram.sram_dq_out = 16'h0000;
        if (in_access) begin
            sram.sram_addr = {word_idx, half_sel};
            if (store_q) begin
                sram.sram_we_n   = 1'b0;
                sram.sram_dq_oe  = 1'b1;
                sram.sram_dq_out = half_sel ? st_val_in[31:16] : st_val_in[15:0];
            end
        end
    end

    // Stall and pass-through: bubble the WB controls while frozen.
    always_comb begin
        ready           = (state_q == S_DONE) || ((state_q == S_IDLE) && !req);
        wb_en_out       = wb_en_in & ready;
        mem_r_en_out    = mem_r_en_in & ready;
        alu_result_out  = alu_result_in;
        wb_reg_dest_out = wb_reg_dest_in;
    end

    assign data_memory_result = {hi_q, lo_q};
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_sram_mem_stage.sv
// Directed bench for sram_mem_stage: one DUT with WAIT_CYCLES = 1 on a
// writable SRAM model, one with WAIT_CYCLES = 3 on a read model that only
// returns valid data on the cycles where the halves must be sampled.
module tb_sram_mem_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT 1 (WAIT_CYCLES = 1) ----------------
    logic        wb_en_in = 0, mem_r_en_in = 0, mem_w_en_in = 0;
    logic [31:0] alu_result_in = 0, st_val_in = 0;
    logic [3:0]  wb_reg_dest_in = 0;
    logic        ready, wb_en_out, mem_r_en_out;
    logic [31:0] alu_result_out, data_memory_result;
    logic [3:0]  wb_reg_dest_out;
    logic [1:0]  dbg_state;

    sram_mem_stage_if #(.SRAM_ADDR_W(18)) sram1 ();

    sram_mem_stage #(.BASE_ADDR(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(1)) dut (
        .clk                (clk),
        .rst                (rst),
        .wb_en_in           (wb_en_in),
        .mem_r_en_in        (mem_r_en_in),
        .mem_w_en_in        (mem_w_en_in),
        .alu_result_in      (alu_result_in),
        .st_val_in          (st_val_in),
        .wb_reg_dest_in     (wb_reg_dest_in),
        .ready              (ready),
        .wb_en_out          (wb_en_out),
        .mem_r_en_out       (mem_r_en_out),
        .alu_result_out     (alu_result_out),
        .wb_reg_dest_out    (wb_reg_dest_out),
        .data_memory_result (data_memory_result),
        .dbg_state          (dbg_state),
        .sram               (sram1)
    );

    // SRAM model 1: 64 half-words, aliased on the low address bits.
    logic [15:0] mem1 [0:63];
    logic        pre_we = 0;
    logic [5:0]  pre_addr = 0;
    logic [15:0] pre_data = 0;
    assign sram1.sram_dq_in = mem1[sram1.sram_addr[5:0]];
    always @(posedge clk) begin
        if (pre_we) mem1[pre_addr] <= pre_data;
        else if (!sram1.sram_we_n && sram1.sram_dq_oe) mem1[sram1.sram_addr[5:0]] <= sram1.sram_dq_out;
    end

    // ---------------- DUT 2 (WAIT_CYCLES = 3) ----------------
    logic        wb_en_in2 = 0, mem_r_en_in2 = 0, mem_w_en_in2 = 0;
    logic [31:0] alu_result_in2 = 0, st_val_in2 = 0;
    logic [3:0]  wb_reg_dest_in2 = 0;
    logic        ready2, wb_en_out2, mem_r_en_out2;
    logic [31:0] alu_result_out2, data_memory_result2;
    logic [3:0]  wb_reg_dest_out2;
    logic [1:0]  dbg_state2;

    sram_mem_stage_if #(.SRAM_ADDR_W(18)) sram2 ();

    sram_mem_stage #(.BASE_ADDR(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(3)) dut2 (
        .clk                (clk),
        .rst                (rst),
        .wb_en_in           (wb_en_in2),
        .mem_r_en_in        (mem_r_en_in2),
        .mem_w_en_in        (mem_w_en_in2),
        .alu_result_in      (alu_result_in2),
        .st_val_in          (st_val_in2),
        .wb_reg_dest_in     (wb_reg_dest_in2),
        .ready              (ready2),
        .wb_en_out          (wb_en_out2),
        .mem_r_en_out       (mem_r_en_out2),
        .alu_result_out     (alu_result_out2),
        .wb_reg_dest_out    (wb_reg_dest_out2),
        .data_memory_result (data_memory_result2),
        .dbg_state          (dbg_state2),
        .sram               (sram2)
    );

    // Read model 2: k2 = index of the current stalled cycle (0 = request seen).
    // Valid data only on cycles 3 (low half) and 6 (high half).
    int k2 = 0;
    always @(posedge clk) k2 <= ready2 ? 0 : k2 + 1;
    assign sram2.sram_dq_in = (k2 == 3 && sram2.sram_addr == 18'd0) ? 16'hCAFE :
                              (k2 == 6 && sram2.sram_addr == 18'd1) ? 16'hF00D : 16'h0BAD;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every cycle with mem_r_en_out high hands a load result to MEM_stage_reg.
    always @(negedge clk) begin
        if (!rst && mem_r_en_out) begin
            if (exp_q.size() == 0) check("sb_unexpected_load", data_memory_result, 32'hFFFF_FFFF);
            else check("sb_load", data_memory_result, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    int          low_cnt;
    logic [17:0] log_addr [0:15];
    logic        log_we_n [0:15];
    logic        log_oe   [0:15];
    logic [15:0] log_dq   [0:15];
    logic        log_wb   [0:15];
    logic        done_wb;
    logic [31:0] done_dmr;

    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic drop_req();
        wb_en_in    = 1'b0;
        mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b0;
    endtask

    // Present one memory op (called #1 after a posedge); logs every stalled
    // cycle and returns #1 after the DONE edge with the request still held.
    task automatic run_op(input logic st, input logic ld, input logic [31:0] addr,
                          input logic [31:0] val, input logic [3:0] dest);
        bit got_done = 0;
        wb_en_in       = ld | st;
        mem_r_en_in    = ld;
        mem_w_en_in    = st;
        alu_result_in  = addr;
        st_val_in      = val;
        wb_reg_dest_in = dest;
        low_cnt        = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) begin
                got_done = 1;
                break;
            end
            if (low_cnt < 16) begin
                log_addr[low_cnt] = sram1.sram_addr;
                log_we_n[low_cnt] = sram1.sram_we_n;
                log_oe[low_cnt]   = sram1.sram_dq_oe;
                log_dq[low_cnt]   = sram1.sram_dq_out;
                log_wb[low_cnt]   = wb_en_out;
            end
            low_cnt++;
        end
        if (!got_done) check("op_timeout", 32'd0, 32'd1);
        done_wb  = wb_en_out;
        done_dmr = data_memory_result;
        check("done_we_n", sram1.sram_we_n, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic wb_any;
        int   lows;
        bit   got2;

        // Preload read data while reset is held.
        preload(6'd0, 16'h5555);
        preload(6'd1, 16'hAAAA);
        preload(6'd4, 16'h3344);
        preload(6'd5, 16'h1122);
        preload(6'd62, 16'h0002);
        preload(6'd63, 16'h9001);

        // Reset state
        @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_we_n", sram1.sram_we_n, 1'b1);
        check("rst_oe", sram1.sram_dq_oe, 1'b0);
        check("rst_addr", sram1.sram_addr, 18'd0);
        check("rst_dmr", data_memory_result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: ALU op, no request -> transparent
        wb_en_in = 1'b1;
        alu_result_in = 32'h0000_0123;
        wb_reg_dest_in = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("alu_ready", ready, 1'b1);
            check("alu_wb_en", wb_en_out, 1'b1);
            check("alu_we_n", sram1.sram_we_n, 1'b1);
        end
        check("alu_pass", alu_result_out, 32'h0000_0123);
        check("alu_dest", wb_reg_dest_out, 4'd5);
        @(posedge clk);
        #1;

        // Test 2: store DEADBEEF to 1028 -> addr 2 = BEEF, addr 3 = DEAD
        run_op(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd0);
        drop_req();
        check("st_low_cnt", low_cnt, 3);
        check("st_idle_we_n", log_we_n[0], 1'b1);
        check("st_lo_addr", log_addr[1], 18'd2);
        check("st_lo_we_n", log_we_n[1], 1'b0);
        check("st_lo_oe", log_oe[1], 1'b1);
        check("st_lo_dq", log_dq[1], 16'hBEEF);
        check("st_hi_addr", log_addr[2], 18'd3);
        check("st_hi_we_n", log_we_n[2], 1'b0);
        check("st_hi_dq", log_dq[2], 16'hDEAD);
        check("st_mem2", mem1[2], 16'hBEEF);
        check("st_mem3", mem1[3], 16'hDEAD);
        check("st_dmr_kept", done_dmr, 32'd0);

        // Test 3: load back from 1028
        exp_q.push_back(32'hDEADBEEF);
        run_op(1'b0, 1'b1, 32'd1028, 32'd0, 4'd7);
        drop_req();
        wb_any = 1'b0;
        for (int i = 0; i < 3; i++) wb_any = wb_any | log_wb[i];
        check("ld_low_cnt", low_cnt, 3);
        check("ld_wb_stalled", wb_any, 1'b0);
        check("ld_wb_done", done_wb, 1'b1);
        check("ld_dmr", done_dmr, 32'hDEADBEEF);
        check("ld_lo_addr", log_addr[1], 18'd2);
        check("ld_lo_we_n", log_we_n[1], 1'b1);

        // Test 4: back-to-back loads, request held through DONE
        exp_q.push_back(32'hAAAA5555);
        exp_q.push_back(32'h11223344);
        run_op(1'b0, 1'b1, 32'd1024, 32'd0, 4'd1);
        check("b2b_first_low", low_cnt, 3);
        check("b2b_first_dmr", done_dmr, 32'hAAAA5555);
        run_op(1'b0, 1'b1, 32'd1032, 32'd0, 4'd2);
        check("b2b_second_low", low_cnt, 3);
        check("b2b_second_addr", log_addr[1], 18'd4);
        check("b2b_second_dmr", done_dmr, 32'h11223344);
        drop_req();
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!ready) lows++;
        end
        check("b2b_no_rearm", lows, 0);
        check("b2b_hold_dmr", data_memory_result, 32'h11223344);
        @(posedge clk);
        #1;

        // Wrap: 1020 is below the base -> word index all ones
        exp_q.push_back(32'h90010002);
        run_op(1'b0, 1'b1, 32'd1020, 32'd0, 4'd3);
        drop_req();
        check("wrap_lo_addr", log_addr[1], 18'h3FFFE);
        check("wrap_hi_addr", log_addr[2], 18'h3FFFF);

        // Both enables set: store wins, load result unchanged
        exp_q.push_back(32'h90010002);
        run_op(1'b1, 1'b1, 32'd1036, 32'hCAFEBABE, 4'd4);
        drop_req();
        check("both_we_n", log_we_n[1], 1'b0);
        check("both_dq_lo", log_dq[1], 16'hBABE);
        check("both_mem6", mem1[6], 16'hBABE);
        check("both_mem7", mem1[7], 16'hCAFE);

        // Test 5: reset asserted during HI of a store
        mem_w_en_in = 1'b1;
        wb_en_in = 1'b1;
        alu_result_in = 32'd1040;
        st_val_in = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_hi_we_n", sram1.sram_we_n, 1'b0);
        check("rst_mid_hi_addr", sram1.sram_addr, 18'd9);
        rst = 1'b1;
        #1;
        check("rst_mid_we_n", sram1.sram_we_n, 1'b1);
        check("rst_mid_oe", sram1.sram_dq_oe, 1'b0);
        check("rst_mid_dmr", data_memory_result, 32'd0);
        @(negedge clk);
        check("rst_mid_state", dbg_state, 2'd0);
        check("rst_mid_addr", sram1.sram_addr, 18'd0);
        drop_req();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", ready, 1'b1);
        @(posedge clk);
        #1;

        // Test 6: WAIT_CYCLES = 3 load from 1024 on DUT 2
        mem_r_en_in2 = 1'b1;
        wb_en_in2 = 1'b1;
        alu_result_in2 = 32'd1024;
        lows = 0;
        got2 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready2) begin
                got2 = 1;
                break;
            end
            lows++;
        end
        if (!got2) check("w3_timeout", 32'd0, 32'd1);
        check("w3_low_cnt", lows, 7);
        check("w3_dmr", data_memory_result2, 32'hF00DCAFE);
        check("w3_wb_done", wb_en_out2, 1'b1);
        @(posedge clk);
        #1;
        mem_r_en_in2 = 1'b0;
        wb_en_in2 = 1'b0;
        @(negedge clk);
        check("w3_idle_ready", ready2, 1'b1);

        // Report
        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Bound the run in case the DUT never returns ready.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
